// File: rtl/adder_accum_pkg.sv
// adder_accum shared types.
// State encoding for the batch accumulator.
package adder_accum_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
endpackage

// File: rtl/adder_cout1.sv
// Unsigned WIDTH-bit adder with carry-out.
// Purely combinational; the accumulator owns all state.
module adder_cout1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/adder_accum.sv
// Streaming batch accumulator: sums COUNT operands,
// then holds sum/carry count until downstream takes it.
module adder_accum
  import adder_accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  localparam int CW = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CW-1:0]    out_carries,
  output logic             out_overflow
);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  state_t           r_state;
  logic             r_in_ready;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_carries;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]    w_carries_nxt;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_beat;

  adder_cout1 #(.WIDTH(WIDTH)) u_add (
    .i_a    (r_acc),
    .i_b    (in_data),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_beat = in_valid && r_in_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_carries_nxt = r_carries;
    unique case (r_state)
      ACCUM: begin
        if (clear) begin
          w_cnt_nxt = '0;
        end else if (w_beat) begin
          if (r_cnt == '0) begin
            w_acc_nxt     = in_data;
            w_carries_nxt = '0;
            w_cnt_nxt     = CW'(1);
          end else begin
            w_acc_nxt     = w_sum;
            w_carries_nxt = r_carries + CW'(w_cout);
            if (r_cnt == LAST) begin
              w_cnt_nxt   = '0;
              w_state_nxt = HOLD;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) w_state_nxt = ACCUM;
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  // in_ready is its own flop so it stays low while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ACCUM;
      r_in_ready <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_carries  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == ACCUM);
      r_cnt      <= w_cnt_nxt;
      r_acc      <= w_acc_nxt;
      r_carries  <= w_carries_nxt;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = (r_state == HOLD);
  assign out_sum      = r_acc;
  assign out_carries  = r_carries;
  assign out_overflow = (r_carries != '0);
endmodule

// File: tb/tb_adder_accum.sv
// Bench for adder_accum: directed batches with literal
// expectations plus random traffic against a batch model.
module tb_adder_accum;
  localparam int WIDTH = 8;
  localparam int COUNT = 4;
  localparam int CW = $clog2(COUNT);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic [CW-1:0]    out_carries;
  logic             out_overflow;

  int errors = 0;
  int checks = 0;

  adder_accum #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carries  (out_carries),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Batch model: collect accepted operands, then the
  // result is total mod 2^W and carries is total >> W.
  int unsigned beats[$];
  logic m_hold, m_live;
  int m_sum, m_car, nres;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      beats.delete();
      m_hold = 1'b0;
      m_live = 1'b0;
      m_sum  = 0;
      m_car  = 0;
    end else begin
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0;
          nres++;
        end
      end else if (clear) begin
        beats.delete();
      end else if (in_valid && m_live) begin
        beats.push_back(int'(in_data));
        if (beats.size() == COUNT) begin
          int unsigned tot;
          tot = 0;
          foreach (beats[k]) tot += beats[k];
          m_sum  = int'(tot % (1 << WIDTH));
          m_car  = int'(tot >> WIDTH);
          m_hold = 1'b1;
          beats.delete();
        end
      end
      m_live = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_sum", int'(out_sum), 0);
      chk("rst_out_carries", int'(out_carries), 0);
    end else begin
      chk("in_ready", int'(in_ready), int'(m_live && !m_hold));
      chk("out_valid", int'(out_valid), int'(m_hold));
      if (m_hold) begin
        chk("out_sum", int'(out_sum), m_sum);
        chk("out_carries", int'(out_carries), m_car);
        chk("out_overflow", int'(out_overflow), int'(m_car != 0));
      end
    end
  end

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_result(input int s, input int c);
    chk("lit_valid", int'(out_valid), 1);
    chk("lit_sum", int'(out_sum), s);
    chk("lit_carries", int'(out_carries), c);
    chk("lit_overflow", int'(out_overflow), int'(c != 0));
  endtask

  task automatic chk_zero();
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_sum", int'(out_sum), 0);
    chk("async_rst_carries", int'(out_carries), 0);
    chk("async_rst_ovf", int'(out_overflow), 0);
    chk("async_rst_ready", int'(in_ready), 0);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int target;
    int cyc;
    #1;
    chk_zero();
    repeat (2) @(posedge clk);
    release_rst();
    chk("ready_after_rst", int'(in_ready), 1);

    send(10); send(20); send(30); send(40);
    chk_result(100, 0);
    @(posedge clk); #1;
    chk("single_cycle_valid", int'(out_valid), 0);
    chk("ready_after_xfer", int'(in_ready), 1);

    send(200); send(100); send(255); send(1);
    chk_result(44, 2);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(50); send(60); send(70); send(80);
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", int'(in_ready), 0);
      chk_result(4, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold_release_valid", int'(out_valid), 0);
    chk("hold_release_ready", int'(in_ready), 1);

    send(5); send(7);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_no_result", int'(out_valid), 0);
    send(1); send(2); send(3); send(4);
    chk_result(10, 0);
    @(posedge clk); #1;

    send(9); send(9);
    #1 rst = 1'b1;
    #1 chk_zero();
    release_rst();
    out_ready = 1'b0;
    send(100); send(100); send(100); send(100);
    chk_result(144, 1);
    #1 rst = 1'b1;
    #1 chk_zero();
    out_ready = 1'b1;
    release_rst();
    send(1); send(1); send(1); send(1);
    chk_result(4, 0);
    @(posedge clk); #1;

    target = nres + 100;
    cyc = 0;
    while (nres < target && cyc < 6000) begin
      in_valid  = ($urandom % 2) == 0;
      in_data   = WIDTH'($urandom);
      out_ready = ($urandom % 4) != 0;
      clear     = ($urandom % 32) == 0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("random_batches_done", int'(nres >= target), 1);
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
